// File: rtl/aud_sram_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aud_sram_pkg
// Description : Shared types and default widths for the audio SRAM arbiter.
//               Contents:
//                 state_e  - access sequencer states
//                 grant_e  - which requester owned the most recent grant
//                 DEFAULT_ADDR_W / DEFAULT_DATA_W - board SRAM geometry
// Revision    : 1.0 - initial release
// ============================================================================
package aud_sram_pkg;

    localparam int DEFAULT_ADDR_W = 20;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_TURN  = 2'd3
    } state_e;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_e;

endpackage : aud_sram_pkg
`default_nettype wire

// File: rtl/aud_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : aud_sram_arbiter
// Description : Shares the board SRAM between the audio recorder (writes) and
//               the DSP (reads). Round-robin arbitration, one bus-turnaround
//               cycle between a write and an immediately following read, and
//               fixed-length CE/OE/WE/DQ sequencing for every access.
// Ports       : i_clk, i_rst_n       - bit clock, async active-low reset
//               i_wr_req/addr/data   - recorder write request (level)
//               o_wr_ack             - pulse in the final write cycle
//               i_rd_req/addr        - DSP read request (level)
//               o_rd_data/o_rd_valid - read result, valid pulse
//               o_SRAM_*/io_SRAM_DQ  - SRAM pins, strobes active-low
// Revision    : 1.0 - initial release
// ============================================================================
module aud_sram_arbiter
    import aud_sram_pkg::*;
#(
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int DATA_W        = DEFAULT_DATA_W,
    parameter int ACCESS_CYCLES = 2              // legal range 1..8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_LB_N,
    output logic              o_SRAM_UB_N
);

    localparam logic [2:0] c_cnt_init = 3'(ACCESS_CYCLES - 1);

    state_e              state_q;
    state_e              prev_state_q;
    grant_e              last_grant_q;
    logic [2:0]          cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_valid_q;
    logic                wr_ack_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic                dq_oe_q;

    // A read port is masked while its valid pulse is out so a held request
    // is not served twice.
    logic w_rd_elig;
    logic w_wr_elig;
    logic w_pick_rd;

    assign w_rd_elig = i_rd_req && !rd_valid_q;
    assign w_wr_elig = i_wr_req;
    assign w_pick_rd = w_rd_elig && (!w_wr_elig || (last_grant_q == GRANT_WR));

    // All pin-facing controls are registered and set one edge ahead of the
    // state they belong to, so the SRAM sees clean strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            prev_state_q <= S_IDLE;
            last_grant_q <= GRANT_WR;
            cnt_q        <= 3'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            dq_oe_q      <= 1'b0;
        end else begin
            prev_state_q <= state_q;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_pick_rd) begin
                        addr_q       <= i_rd_addr;
                        cnt_q        <= c_cnt_init;
                        last_grant_q <= GRANT_RD;
                        if (prev_state_q == S_WRITE) begin
                            // Let the SRAM release DQ before OE opens.
                            state_q <= S_TURN;
                        end else begin
                            state_q <= S_READ;
                            ce_n_q  <= 1'b0;
                            oe_n_q  <= 1'b0;
                        end
                    end else if (w_wr_elig) begin
                        addr_q       <= i_wr_addr;
                        wdata_q      <= i_wr_data;
                        cnt_q        <= c_cnt_init;
                        last_grant_q <= GRANT_WR;
                        state_q      <= S_WRITE;
                        ce_n_q       <= 1'b0;
                        we_n_q       <= 1'b0;
                        dq_oe_q      <= 1'b1;
                        // A one-cycle access is also its own final cycle.
                        wr_ack_q     <= (c_cnt_init == 3'd0);
                    end
                end

                S_TURN: begin
                    state_q <= S_READ;
                    cnt_q   <= c_cnt_init;
                    ce_n_q  <= 1'b0;
                    oe_n_q  <= 1'b0;
                end

                S_READ: begin
                    if (cnt_q == 3'd0) begin
                        rd_data_q  <= io_SRAM_DQ;
                        rd_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                        ce_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                S_WRITE: begin
                    if (cnt_q == 3'd0) begin
                        state_q <= S_IDLE;
                        ce_n_q  <= 1'b1;
                        we_n_q  <= 1'b1;
                        dq_oe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                        // Last cycle: WE released early, data still held.
                        if (cnt_q == 3'd1) begin
                            we_n_q   <= 1'b1;
                            wr_ack_q <= 1'b1;
                        end
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign io_SRAM_DQ  = dq_oe_q ? wdata_q : {DATA_W{1'bz}};
    assign o_SRAM_ADDR = addr_q;
    assign o_SRAM_CE_N = ce_n_q;
    assign o_SRAM_OE_N = oe_n_q;
    assign o_SRAM_WE_N = we_n_q;
    assign o_SRAM_LB_N = ce_n_q;
    assign o_SRAM_UB_N = ce_n_q;
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_wr_ack    = wr_ack_q;

endmodule : aud_sram_arbiter
`default_nettype wire

// File: tb/tb_aud_sram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_aud_sram_arbiter
// Description : Self-checking bench for aud_sram_arbiter with a small
//               behavioural SRAM model (ACCESS_CYCLES = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aud_sram_arbiter;
    import aud_sram_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_dq;
    logic          ce_n, oe_n, we_n, lb_n, ub_n;

    always #5 clk = ~clk;

    aud_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .o_wr_ack(wr_ack),
        .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_SRAM_ADDR(sram_addr), .io_SRAM_DQ(sram_dq),
        .o_SRAM_CE_N(ce_n), .o_SRAM_OE_N(oe_n), .o_SRAM_WE_N(we_n),
        .o_SRAM_LB_N(lb_n), .o_SRAM_UB_N(ub_n)
    );

    // SRAM model: asynchronous read, write captured while CE and WE are low.
    logic [DW-1:0] mem [0:4095];
    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[11:0]] : {DW{1'bz}};
    always @(posedge clk) if (!ce_n && !we_n) mem[sram_addr[11:0]] = sram_dq;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after a negedge. Raises one request, watches until the
    // ack/valid pulse, then drops the request in that same cycle.
    task automatic run_txn(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int lat, output int low, output int dqc, output bit to);
        lat = 0; low = 0; dqc = 0; to = 1'b1;
        if (is_wr) begin wr_req = 1'b1; wr_addr = a; wr_data = d; end
        else begin rd_req = 1'b1; rd_addr = a; end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            lat++;
            if (is_wr) begin
                if (!we_n) low++;
                if (dut.dq_oe_q && sram_dq == d) dqc++;
            end else if (!oe_n) begin
                low++;
            end
            if ((is_wr && wr_ack) || (!is_wr && rd_valid)) begin
                to = 1'b0;
                break;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;     // write data, or expected read data
        int            exp_lat;  // negedges from request to ack/valid
        int            exp_low;  // cycles with OE_N (read) or WE_N (write) low
        int            exp_dq;   // cycles with write data driven on DQ
    } vec_t;

    vec_t vec [6];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int lat, low, dqc, t, gap, rd_t, wr_t, nv, oe_cnt;
        bit to, seen_oe;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h010] = 16'hBEEF;
        for (int i = 0; i < 4; i++) mem[12'h200 + i] = 16'h1000 + 16'(i);

        vec[0] = '{1'b0, 20'h00010, 16'hBEEF, 3, 2, 0};
        vec[1] = '{1'b1, 20'h0ABCD, 16'h1234, 2, 1, 2};
        vec[2] = '{1'b0, 20'h0ABCD, 16'h1234, 3, 2, 0};
        vec[3] = '{1'b1, 20'h00100, 16'hCAFE, 2, 1, 2};
        vec[4] = '{1'b0, 20'h00100, 16'hCAFE, 3, 2, 0};
        vec[5] = '{1'b0, 20'h00010, 16'hBEEF, 3, 2, 0};

        // ---- reset values, sampled while reset is held
        rst_n = 1'b0;
        @(negedge clk);
        check("rst strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
        check("rst addr", 32'(sram_addr), 32'h0);
        check("rst rd_data", 32'(rd_data), 32'h0);
        check("rst pulses", {30'd0, wr_ack, rd_valid}, 32'h0);
        check("rst dq_oe", 32'(dut.dq_oe_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- table of single transactions from idle
        for (int k = 0; k < 6; k++) begin
            run_txn(vec[k].is_wr, vec[k].addr, vec[k].data, lat, low, dqc, to);
            check($sformatf("v%0d timeout", k), 32'(to), 32'h0);
            check($sformatf("v%0d latency", k), 32'(lat), 32'(vec[k].exp_lat));
            check($sformatf("v%0d strobe_low", k), 32'(low), 32'(vec[k].exp_low));
            if (vec[k].is_wr) begin
                check($sformatf("v%0d dq_cycles", k), 32'(dqc), 32'(vec[k].exp_dq));
                check($sformatf("v%0d mem", k), 32'(mem[vec[k].addr[11:0]]), 32'(vec[k].data));
            end else begin
                check($sformatf("v%0d rd_data", k), 32'(rd_data), 32'(vec[k].data));
            end
            @(negedge clk);
            check($sformatf("v%0d pulse_end", k), {30'd0, wr_ack, rd_valid}, 32'h0);
            check($sformatf("v%0d dq_release", k), 32'(dut.dq_oe_q), 32'h0);
            check($sformatf("v%0d ce_idle", k), 32'(ce_n), 32'h1);
            @(negedge clk);
            if (!vec[k].is_wr)
                check($sformatf("v%0d rd_hold", k), 32'(rd_data), 32'(vec[k].data));
        end

        // ---- simultaneous requests after reset: read wins, then write
        do_reset();
        rd_req = 1'b1; rd_addr = 20'h00010;
        wr_req = 1'b1; wr_addr = 20'h00400; wr_data = 16'h4444;
        rd_t = -1; wr_t = -1; t = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); t++;
            if (rd_valid && rd_t < 0) begin rd_t = t; rd_req = 1'b0; end
            if (wr_ack) begin wr_t = t; wr_req = 1'b0; break; end
        end
        check("tie1 rd_time", 32'(rd_t), 32'd3);
        check("tie1 wr_time", 32'(wr_t), 32'd5);
        check("tie1 mem", 32'(mem[12'h400]), 32'h4444);

        // second pair raised during the write's ack cycle: read wins after a turnaround
        rd_req = 1'b1; rd_addr = 20'h00010;
        wr_req = 1'b1; wr_addr = 20'h00404; wr_data = 16'h5555;
        rd_t = -1; wr_t = -1; t = 0; gap = 0; seen_oe = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); t++;
            if (!seen_oe) begin
                if (!oe_n) seen_oe = 1'b1;
                else if (ce_n) gap++;
            end
            if (rd_valid && rd_t < 0) begin rd_t = t; rd_req = 1'b0; end
            if (wr_ack) begin wr_t = t; wr_req = 1'b0; break; end
        end
        check("tie2 gap", 32'(gap), 32'd2);
        check("tie2 rd_time", 32'(rd_t), 32'd5);
        check("tie2 wr_time", 32'(wr_t), 32'd7);
        check("tie2 rd_data", 32'(rd_data), 32'hBEEF);
        repeat (2) @(negedge clk);

        // ---- write then read of the same word, read raised in the ack cycle
        run_txn(1'b1, 20'h00020, 16'h5A5A, lat, low, dqc, to);
        check("wr20 latency", 32'(lat), 32'd2);
        rd_req = 1'b1; rd_addr = 20'h00020;
        t = 0; gap = 0; seen_oe = 1'b0; rd_t = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); t++;
            if (!seen_oe) begin
                if (!oe_n) seen_oe = 1'b1;
                else if (ce_n) gap++;
            end
            if (rd_valid) begin rd_t = t; break; end
        end
        rd_req = 1'b0;
        check("wr_rd gap", 32'(gap), 32'd2);
        check("wr_rd latency", 32'(rd_t), 32'd5);
        check("wr_rd data", 32'(rd_data), 32'h5A5A);
        repeat (2) @(negedge clk);

        // ---- held read request, address stepped after each valid
        rd_req = 1'b1; rd_addr = 20'h00200;
        nv = 0; oe_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!oe_n) oe_cnt++;
            if (rd_valid) begin
                check($sformatf("stream%0d data", nv), 32'(rd_data), 32'h1000 + 32'(nv));
                nv++;
                if (nv >= 4) rd_req = 1'b0;
                else rd_addr = 20'h00200 + 20'(nv);
            end
        end
        rd_req = 1'b0;
        check("stream reads", 32'(nv), 32'd4);
        check("stream oe_cycles", 32'(oe_cnt), 32'd8);

        // ---- asynchronous reset in the middle of a write
        wr_req = 1'b1; wr_addr = 20'h00300; wr_data = 16'h7777;
        @(negedge clk);
        check("midwr we_low", 32'(we_n), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midwr ce", 32'(ce_n), 32'h1);
        check("midwr we", 32'(we_n), 32'h1);
        check("midwr dq_oe", 32'(dut.dq_oe_q), 32'h0);
        check("midwr addr", 32'(sram_addr), 32'h0);
        wr_req = 1'b0;
        t = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (wr_ack) t++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (wr_ack) t++;
        check("midwr no_ack", 32'(t), 32'h0);
        check("midwr state", 32'(dut.state_q), 32'(S_IDLE));
        check("midwr mem", 32'(mem[12'h300]), 32'h0);
        run_txn(1'b0, 20'h00010, 16'hBEEF, lat, low, dqc, to);
        check("post_rst rd latency", 32'(lat), 32'd3);
        check("post_rst rd data", 32'(rd_data), 32'hBEEF);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_aud_sram_arbiter
`default_nettype wire

// File: doc/aud_sram_arbiter.md
Name: aud_sram_arbiter

Overview:
Shares the single board SRAM between the audio recorder (write requester) and the DSP (read requester), sequencing CE/OE/WE/DQ timing for each access. Sits between those two blocks and the SRAM pins in the audio top level, running on the audio bit clock. Arbitration is round-robin, with a bus-turnaround cycle between a write and a following read.

Parameters:
ADDR_W, 20, SRAM word-address width
DATA_W, 16, SRAM data width
ACCESS_CYCLES, 2, cycles the SRAM strobes are held per access (legal range 1..8)

Ports:
i_clk  in  1  audio bit clock, rising edge; the block's only clock
i_rst_n  in  1  asynchronous reset, active-low
i_wr_req  in  1  recorder write request (level, held until o_wr_ack)
i_wr_addr  in  ADDR_W  write address (stable while i_wr_req is high)
i_wr_data  in  DATA_W  write data (stable while i_wr_req is high)
o_wr_ack  out  1  one-cycle pulse: write completing this cycle
i_rd_req  in  1  DSP read request (level, held until o_rd_valid)
i_rd_addr  in  ADDR_W  read address (stable while i_rd_req is high)
o_rd_data  out  DATA_W  read data; holds its last value until the next read completes
o_rd_valid  out  1  one-cycle pulse: o_rd_data updated
o_SRAM_ADDR  out  ADDR_W  SRAM address
io_SRAM_DQ  inout  DATA_W  SRAM data bus; driven only during S_WRITE, high-Z otherwise
o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_LB_N, o_SRAM_UB_N  out  1 each  SRAM strobes, active-low

Behaviour:
- Interface: one clock, i_clk. Reset i_rst_n is asynchronous and active-low.
- Reset values, applied immediately and asynchronously, including mid-access:
  - state S_IDLE; CE_N, OE_N, WE_N, LB_N, UB_N all 1; DQ high-Z.
  - o_SRAM_ADDR 0, o_rd_data 0, o_wr_ack 0, o_rd_valid 0.
  - last_grant = WR, so the read port wins the first tie.
- States: S_IDLE, S_READ, S_WRITE, S_TURN. A 3-bit down-counter cnt times each access.
- S_IDLE:
  - Eligible ports: rd if i_rd_req && !o_rd_valid; wr if i_wr_req.
  - One eligible port: grant it. Both eligible: grant the port that is not last_grant.
  - On the granting edge: latch the address (and data for a write) into registers, set cnt = ACCESS_CYCLES-1, update last_grant.
  - Entry target: grant WR -> S_WRITE. Grant RD -> S_READ, or S_TURN if the previous state was S_WRITE.
  - In IDLE all strobes are high and DQ is high-Z.
- S_TURN: exactly 1 cycle. Strobes high, DQ high-Z. Then S_READ with cnt reloaded to ACCESS_CYCLES-1.
- S_READ:
  - CE_N=0, OE_N=0, WE_N=1, LB_N=UB_N=0, o_SRAM_ADDR = latched address, DQ high-Z.
  - When cnt==0: on that edge, capture io_SRAM_DQ into o_rd_data, set o_rd_valid=1 for the next cycle, go to S_IDLE. Otherwise decrement cnt.
- S_WRITE:
  - CE_N=0, OE_N=1, LB_N=UB_N=0, address and data driven for all cycles.
  - WE_N=0 in every S_WRITE cycle except the last, which keeps WE_N=1 for data hold.
  - If ACCESS_CYCLES==1, WE_N=0 for that single cycle.
  - o_wr_ack=1 during the last S_WRITE cycle (cnt==0). Next state S_IDLE.
- All strobe, address and DQ outputs are registered or decoded from state registers only, so they are glitch-free.
- Latency, ACCESS_CYCLES=2, read from IDLE with no turnaround: request sampled at edge E0; o_rd_valid high in the cycle after edge E0+2. Each added cycle of ACCESS_CYCLES adds one cycle.
- Fairness: a continuously requesting port waits at most one access of the other port plus one S_TURN.
- Requester rules:
  - A requester deasserts or changes its request on the edge that ends its ack/valid cycle.
  - A write port that keeps i_wr_req high after o_wr_ack is treated as a new request.
  - A read port is masked during its o_rd_valid cycle, which prevents a double read.
- Requests that drop before being granted are ignored and no access occurs.
- Address and data inputs are not sampled outside the IDLE granting edge.

Decomposition:
- Package aud_sram_pkg:
  - state enum {S_IDLE, S_READ, S_WRITE, S_TURN}
  - grant enum {GRANT_RD, GRANT_WR}
  - default ADDR_W and DATA_W constants
- No sub-module. The 2-way round-robin pick is a few lines inside this block.

Test Plan:
- Reset, then a single read of address 0x00010 (SRAM model returns 0xBEEF), ACCESS_CYCLES=2 -> OE_N low for exactly 2 cycles, o_rd_valid one pulse 3 edges after the request is sampled, o_rd_data=0xBEEF held afterwards.
- Single write of 0x1234 to 0x0ABCD -> WE_N low 1 cycle, DQ driven 2 cycles, o_wr_ack pulses in the 2nd cycle, model memory[0x0ABCD]=0x1234, DQ high-Z afterwards.
- Both requests raised in the same cycle after reset -> read served first; then the write; a second simultaneous pair -> read, with S_TURN inserted (one cycle with all strobes high) between the write and that read.
- Write-then-read to the same address 0x00020 with value 0x5A5A -> the read returns 0x5A5A and exactly one S_TURN cycle separates WE_N release from OE_N assert.
- i_rd_req held high through o_rd_valid, with address stepping by 1 for 4 reads -> exactly 4 accesses, no duplicate read of any address.
- Assert i_rst_n low in mid-S_WRITE -> WE_N and CE_N go to 1 and DQ to high-Z within the same cycle (asynchronous); no o_wr_ack; after release, state is S_IDLE.
